// File: rtl/piso_shift_dbuf_pkg.sv
// Shared types and helpers for the CW305 SPI-side serialiser datapath.
package ml_spi_pkg;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

endpackage

// File: rtl/piso_shift_dbuf_hold_buf.sv
// One-entry valid/ready holding register feeding the PISO shifter.
module piso_hold_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         accept;

    assign accept = valid_i & ~full_q;

    // Pop first so an accept on the same edge leaves the entry full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = ~full_q;
    assign data_o  = data_q;
    assign full_o  = full_q;

endmodule

// File: rtl/piso_shift_dbuf.sv
// Parallel-in/serial-out shifter with a one-word holding buffer for gapless streaming.
module piso_shift_dbuf #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LSB_FIRST  = 0,
    parameter int unsigned IDLE_LEVEL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              en_L,
    output logic              so,
    output logic              so_valid,
    output logic              so_first,
    output logic              done,
    output logic              busy
);
    import ml_spi_pkg::*;

    if (DATA_W < 2) begin : g_bad_width
        $error("piso_shift_dbuf: DATA_W must be >= 2");
    end

    localparam bit_order_e        ORDER    = (LSB_FIRST != 0) ? ml_spi_pkg::LSB_FIRST : MSB_FIRST;
    localparam int unsigned       CW       = cnt_width(DATA_W);
    localparam logic [CW-1:0]     LAST     = CW'(DATA_W - 1);
    localparam logic              IDLE_BIT = 1'(IDLE_LEVEL);

    shift_state_e      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              so_q, so_d;
    logic              so_valid_q, so_valid_d;
    logic              so_first_q, so_first_d;
    logic              done_q, done_d;

    logic              hold_full, hold_pop, retire;
    logic [DATA_W-1:0] hold_data;

    piso_hold_buf #(.W(DATA_W)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .data_i  (in_data),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .pop_i   (hold_pop),
        .data_o  (hold_data),
        .full_o  (hold_full)
    );

    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return (ORDER == MSB_FIRST) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        return (ORDER == MSB_FIRST) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    assign retire = (state_q == SHIFT) && !en_L && (cnt_q == LAST);

    // The register sr_q always holds the not-yet-presented bits at its head end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        so_d       = so_q;
        so_valid_d = so_valid_q;
        so_first_d = so_first_q;
        done_d     = 1'b0;
        hold_pop   = 1'b0;

        if (state_q == SHIFT && !en_L) begin
            if (cnt_q != LAST) begin
                so_d       = head_bit(sr_q);
                sr_d       = advance(sr_q);
                cnt_d      = cnt_q + CW'(1);
                so_first_d = 1'b0;
            end else begin
                done_d     = 1'b1;
                state_d    = IDLE;
                so_d       = IDLE_BIT;
                so_valid_d = 1'b0;
                so_first_d = 1'b0;
            end
        end

        if (hold_full && (state_q == IDLE || retire)) begin
            hold_pop   = 1'b1;
            state_d    = SHIFT;
            cnt_d      = '0;
            so_d       = head_bit(hold_data);
            sr_d       = advance(hold_data);
            so_valid_d = 1'b1;
            so_first_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            so_q       <= IDLE_BIT;
            so_valid_q <= 1'b0;
            so_first_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            so_first_q <= so_first_d;
            done_q     <= done_d;
        end
    end

    assign so       = so_q;
    assign so_valid = so_valid_q;
    assign so_first = so_first_q;
    assign done     = done_q;
    assign busy     = hold_full | (state_q == SHIFT);

endmodule

// File: tb/tb_piso_shift_dbuf.sv
// Scoreboard bench for piso_shift_dbuf: 8-bit MSB-first and 16-bit LSB-first/idle-high builds.
module tb_piso_shift_dbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit fin [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned W    = (g == 0) ? 8 : 16;
        localparam int unsigned LSBF = g;
        localparam int unsigned IDL  = g;

        logic         rst = 1'b1;
        logic         in_valid, in_ready, en_L;
        logic         so, so_valid, so_first, done, busy;
        logic [W-1:0] in_data;

        // Reference: words accepted but not fully retired, and the bit index within the front word.
        logic [W-1:0] words [$];
        int           bit_idx  = 0;
        bit           exp_done = 1'b0;
        bit           fresh    = 1'b0;

        piso_shift_dbuf #(.DATA_W(W), .LSB_FIRST(LSBF), .IDLE_LEVEL(IDL)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .en_L     (en_L),
            .so       (so),
            .so_valid (so_valid),
            .so_first (so_first),
            .done     (done),
            .busy     (busy)
        );

        // Handshake observer: a word seen with valid&ready now transfers on the next edge.
        always @(negedge clk) begin
            #1;
            if (!rst && in_valid && in_ready) begin
                if (words.size() == 0) fresh = 1'b1;
                words.push_back(in_data);
            end
        end

        // Monitor: compare DUT outputs with the reference between edges.
        always @(negedge clk) begin
            logic [W-1:0] w;
            logic         eb;
            if (!rst) begin
                chk($sformatf("g%0d done", g), done, exp_done);
                exp_done = 1'b0;
                chk($sformatf("g%0d busy", g), busy, words.size() != 0);
                chk($sformatf("g%0d in_ready", g), in_ready, !(fresh || words.size() >= 2));
                if (fresh || words.size() == 0) begin
                    chk($sformatf("g%0d so_valid idle", g), so_valid, 0);
                    chk($sformatf("g%0d so idle", g), so, IDL);
                    chk($sformatf("g%0d so_first idle", g), so_first, 0);
                end else begin
                    w  = words[0];
                    eb = (LSBF != 0) ? w[bit_idx] : w[W-1-bit_idx];
                    chk($sformatf("g%0d so_valid", g), so_valid, 1);
                    chk($sformatf("g%0d so bit%0d", g, bit_idx), so, eb);
                    chk($sformatf("g%0d so_first", g), so_first, bit_idx == 0);
                    if (!en_L) begin
                        bit_idx++;
                        if (bit_idx == W) begin
                            void'(words.pop_front());
                            bit_idx  = 0;
                            exp_done = 1'b1;
                        end
                    end
                end
                fresh = 1'b0;
            end
        end

        task automatic idle(input int n);
            in_valid = 1'b0;
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic send(input logic [W-1:0] d);
            bit ok = 1'b0;
            in_valid = 1'b1;
            in_data  = d;
            for (int t = 0; t < 64 && !ok; t++) begin
                @(negedge clk);
                #2;
                ok = in_ready;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            chk($sformatf("g%0d send accepted", g), ok, 1);
        endtask

        initial begin
            in_valid = 1'b0;
            en_L     = 1'b0;
            in_data  = '0;
            rst      = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("g%0d rst so", g), so, IDL);
            chk($sformatf("g%0d rst so_valid", g), so_valid, 0);
            chk($sformatf("g%0d rst so_first", g), so_first, 0);
            chk($sformatf("g%0d rst done", g), done, 0);
            chk($sformatf("g%0d rst busy", g), busy, 0);
            chk($sformatf("g%0d rst in_ready", g), in_ready, 1);
            rst = 1'b0;

            send(W'(32'hA5));
            idle(W + 4);
            send(W'(32'h1E));
            idle(W + 4);
            send(W'(32'hFFFF));
            send(W'(32'h0000));
            idle(2 * W + 4);

            send(W'(32'hA5));
            idle(3);
            en_L = 1'b1;
            idle(3);
            en_L = 1'b0;
            idle(W + 3);

            send(W'(32'h3C));
            send(W'(32'hC3));
            in_valid = 1'b1;
            in_data  = W'(32'h77);
            @(posedge clk);
            #1;
            idle(2 * W + 4);

            send(W'(32'h8001));
            idle(W + 3);

            for (int i = 0; i < 400; i++) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = W'($urandom);
                en_L     = ($urandom_range(0, 3) == 0);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            en_L     = 1'b0;
            for (int t = 0; t < 4 * W + 8 && words.size() != 0; t++) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("g%0d drained", g), words.size(), 0);
            idle(2);

            send(W'(32'hA5));
            send(W'(32'h5A));
            idle(3);
            #2;
            rst = 1'b1;
            #1;
            chk($sformatf("g%0d midrst so", g), so, IDL);
            chk($sformatf("g%0d midrst so_valid", g), so_valid, 0);
            chk($sformatf("g%0d midrst busy", g), busy, 0);
            chk($sformatf("g%0d midrst in_ready", g), in_ready, 1);
            chk($sformatf("g%0d midrst done", g), done, 0);
            words.delete();
            bit_idx  = 0;
            exp_done = 1'b0;
            fresh    = 1'b0;
            @(negedge clk);
            #3;
            rst = 1'b0;
            @(posedge clk);
            #1;
            idle(W + 4);
            fin[g] = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 60000 && !(fin[0] && fin[1]); t++) @(posedge clk);
        chk("finish", fin[0] && fin[1], 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
